// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse protocol constants and scheduler types.
// Imported by the command scheduler and its init ROM.
package ps2_pkg;

    localparam logic [7:0] PS2_RESET       = 8'hFF;
    localparam logic [7:0] PS2_SET_DEFAULT = 8'hF6;
    localparam logic [7:0] PS2_SET_RATE    = 8'hF3;
    localparam logic [7:0] PS2_RATE_200    = 8'hC8;
    localparam logic [7:0] PS2_ENABLE      = 8'hF4;
    localparam logic [7:0] PS2_ACK         = 8'hFA;
    localparam logic [7:0] PS2_RESEND      = 8'hFE;
    localparam logic [7:0] PS2_ERROR       = 8'hFC;
    localparam logic [7:0] PS2_BAT_OK      = 8'hAA;

    localparam int ROM_IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_DONE,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_FAIL
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_ACK_RETRY = 2'd1,
        ERR_BAT       = 2'd2,
        ERR_TX_RETRY  = 2'd3
    } err_t;

endpackage

// File: rtl/ps2_init_rom.sv
// Mouse init sequence: reset, set default, set sample rate, 200 Hz, enable reporting.
// Purely combinational lookup; last flags the final byte of the sequence.
module ps2_init_rom
    import ps2_pkg::*;
(
    input  logic [ROM_IDX_W-1:0] idx,
    output logic [7:0]           data,
    output logic                 last
);

    always_comb begin
        data = PS2_RESET;
        last = 1'b0;
        case (idx)
            3'd0:    data = PS2_RESET;
            3'd1:    data = PS2_SET_DEFAULT;
            3'd2:    data = PS2_SET_RATE;
            3'd3:    data = PS2_RATE_200;
            3'd4: begin
                data = PS2_ENABLE;
                last = 1'b1;
            end
            default: begin
                data = PS2_ENABLE;
                last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ps2_cmd_sched.sv
// PS/2 mouse command scheduler: runs the built-in init sequence or single host
// command bytes, handling ACK/resend/timeout retries and the BAT/ID handshake.
module ps2_cmd_sched
    import ps2_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 3,
    parameter int BAT_TIMEOUT = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_start,
    input  logic       host_cmd_valid,
    input  logic [7:0] host_cmd_data,
    output logic       host_cmd_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       tx_done,
    input  logic       tx_err,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       busy,
    output logic       init_done,
    output logic       fail,
    output logic [1:0] err_code
);

    localparam int TMAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] ACK_LIMIT = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BAT_LIMIT = TW'(BAT_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_t                 state_reg, state_next;
    logic [ROM_IDX_W-1:0]   idx_reg, idx_next;
    logic [7:0]             host_byte_reg, host_byte_next;
    logic                   in_init_reg, in_init_next;
    logic [RW-1:0]          retry_reg, retry_next;
    logic [TW-1:0]          timer_reg, timer_next;
    logic                   pending_reg, pending_next;
    logic                   init_done_reg, init_done_next;
    logic                   fail_reg, fail_next;
    err_t                   err_reg, err_next;
    logic                   resp_valid_reg, resp_valid_next;
    logic [7:0]             resp_data_reg, resp_data_next;
    logic                   run_reg;

    logic [7:0]             rom_byte;
    logic                   rom_last;
    logic [7:0]             cur_byte;
    logic [TW-1:0]          timer_inc;
    logic                   start_init;
    logic                   retry_req;
    err_t                   retry_err;

    ps2_init_rom u_rom (
        .idx  (idx_reg),
        .data (rom_byte),
        .last (rom_last)
    );

    assign cur_byte   = in_init_reg ? rom_byte : host_byte_reg;
    assign busy       = (state_reg != ST_IDLE) && (state_reg != ST_FAIL);
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign init_done  = init_done_reg;
    assign fail       = fail_reg;
    assign err_code   = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            host_byte_reg  <= '0;
            in_init_reg    <= 1'b0;
            retry_reg      <= '0;
            timer_reg      <= '0;
            pending_reg    <= 1'b0;
            init_done_reg  <= 1'b0;
            fail_reg       <= 1'b0;
            err_reg        <= ERR_NONE;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            run_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            host_byte_reg  <= host_byte_next;
            in_init_reg    <= in_init_next;
            retry_reg      <= retry_next;
            timer_reg      <= timer_next;
            pending_reg    <= pending_next;
            init_done_reg  <= init_done_next;
            fail_reg       <= fail_next;
            err_reg        <= err_next;
            resp_valid_reg <= resp_valid_next;
            resp_data_reg  <= resp_data_next;
            run_reg        <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        host_byte_next  = host_byte_reg;
        in_init_next    = in_init_reg;
        retry_next      = retry_reg;
        timer_next      = timer_reg;
        pending_next    = pending_reg;
        init_done_next  = init_done_reg;
        fail_next       = fail_reg;
        err_next        = err_reg;
        resp_valid_next = 1'b0;
        resp_data_next  = resp_data_reg;
        host_cmd_ready  = 1'b0;
        tx_valid        = 1'b0;
        tx_data         = 8'h00;
        start_init      = 1'b0;
        retry_req       = 1'b0;
        retry_err       = ERR_NONE;
        timer_inc       = (&timer_reg) ? timer_reg : timer_reg + TW'(1);

        case (state_reg)
            ST_IDLE: begin
                // run_reg keeps ready low while reset is asserted
                host_cmd_ready = run_reg && !pending_reg;
                if (rx_valid) begin
                    resp_valid_next = 1'b1;
                    resp_data_next  = rx_data;
                end
                if (pending_reg) begin
                    start_init   = 1'b1;
                    pending_next = 1'b0;
                    in_init_next = 1'b1;
                    idx_next     = '0;
                    retry_next   = '0;
                    state_next   = ST_SEND;
                end else if (host_cmd_valid && host_cmd_ready) begin
                    host_byte_next = host_cmd_data;
                    in_init_next   = 1'b0;
                    retry_next     = '0;
                    state_next     = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = cur_byte;
                if (tx_ready) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    timer_next = '0;
                    state_next = ST_WAIT_ACK;
                end else if (tx_err) begin
                    retry_req = 1'b1;
                    retry_err = ERR_TX_RETRY;
                end
            end
            ST_WAIT_ACK: begin
                // a received byte beats a simultaneous timeout expiry
                if (rx_valid) begin
                    if (rx_data == PS2_ACK) begin
                        retry_next = '0;
                        if (cur_byte == PS2_RESET) begin
                            timer_next = '0;
                            state_next = ST_WAIT_BAT;
                        end else if (!in_init_reg) begin
                            state_next = ST_IDLE;
                        end else if (rom_last) begin
                            in_init_next   = 1'b0;
                            init_done_next = 1'b1;
                            state_next     = ST_IDLE;
                        end else begin
                            idx_next   = idx_reg + ROM_IDX_W'(1);
                            state_next = ST_SEND;
                        end
                    end else if (rx_data == PS2_RESEND || rx_data == PS2_ERROR) begin
                        retry_req = 1'b1;
                        retry_err = ERR_ACK_RETRY;
                    end else begin
                        resp_valid_next = 1'b1;
                        resp_data_next  = rx_data;
                    end
                end else if (timer_reg >= ACK_LIMIT) begin
                    retry_req = 1'b1;
                    retry_err = ERR_ACK_RETRY;
                end else begin
                    timer_next = timer_inc;
                end
            end
            ST_WAIT_BAT: begin
                if (rx_valid) begin
                    if (rx_data == PS2_BAT_OK) begin
                        state_next = ST_WAIT_ID;
                    end else if (rx_data == PS2_ERROR) begin
                        fail_next    = 1'b1;
                        err_next     = ERR_BAT;
                        in_init_next = 1'b0;
                        state_next   = ST_FAIL;
                    end else begin
                        resp_valid_next = 1'b1;
                        resp_data_next  = rx_data;
                    end
                end else if (timer_reg >= BAT_LIMIT) begin
                    fail_next    = 1'b1;
                    err_next     = ERR_BAT;
                    in_init_next = 1'b0;
                    state_next   = ST_FAIL;
                end else begin
                    timer_next = timer_inc;
                end
            end
            ST_WAIT_ID: begin
                if (rx_valid) begin
                    resp_valid_next = 1'b1;
                    resp_data_next  = rx_data;
                    if (in_init_reg) begin
                        idx_next   = idx_reg + ROM_IDX_W'(1);
                        retry_next = '0;
                        state_next = ST_SEND;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_FAIL: begin
            end
            default: state_next = ST_IDLE;
        endcase

        if (retry_req) begin
            if (retry_reg == RETRY_MAX) begin
                fail_next    = 1'b1;
                err_next     = retry_err;
                in_init_next = 1'b0;
                state_next   = ST_FAIL;
            end else begin
                retry_next = retry_reg + RW'(1);
                state_next = ST_SEND;
            end
        end

        // init_start is dropped while init is running; otherwise it is queued for IDLE
        if (init_start) begin
            init_done_next = 1'b0;
            if (state_reg == ST_FAIL) begin
                fail_next    = 1'b0;
                err_next     = ERR_NONE;
                pending_next = 1'b1;
                state_next   = ST_IDLE;
            end else if (!in_init_reg && !start_init) begin
                pending_next = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// Directed bench for ps2_cmd_sched: a scripted device answers each byte while a
// per-cycle checker compares transmitted and forwarded bytes with expected queues.
module tb_ps2_cmd_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       init_start = 1'b0;
    logic       host_cmd_valid = 1'b0;
    logic [7:0] host_cmd_data = 8'h00;
    logic       host_cmd_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
    logic       tx_done = 1'b0;
    logic       tx_err = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       busy;
    logic       init_done;
    logic       fail;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_resp[$];
    logic rx_seen = 1'b0;

    always #5 clk = ~clk;

    ps2_cmd_sched #(
        .ACK_TIMEOUT (20),
        .MAX_RETRY   (3),
        .BAT_TIMEOUT (40)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_start     (init_start),
        .host_cmd_valid (host_cmd_valid),
        .host_cmd_data  (host_cmd_data),
        .host_cmd_ready (host_cmd_ready),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .tx_done        (tx_done),
        .tx_err         (tx_err),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .busy           (busy),
        .init_done      (init_done),
        .fail           (fail),
        .err_code       (err_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Every accepted tx byte and every forwarded resp byte is matched against the model queues.
    always @(posedge clk) rx_seen <= rx_valid;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got %02h required no transmission", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_tx.pop_front());
                end
            end
            if (resp_valid) begin
                check("resp_one_cycle_after_rx", rx_seen, 1);
                if (exp_resp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got %02h required no response", resp_data);
                end else begin
                    check("resp_byte", resp_data, exp_resp.pop_front());
                end
            end
        end
    end

    // Model of a full init: FF, F6, F3 (f3_sends times), C8, F4; the ID byte 00 shows on resp.
    task automatic expect_init(input int f3_sends);
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'hF6);
        for (int i = 0; i < f3_sends; i++) exp_tx.push_back(8'hF3);
        exp_tx.push_back(8'hC8);
        exp_tx.push_back(8'hF4);
        exp_resp.push_back(8'h00);
    endtask

    task automatic drained(input string name);
        check({name, "_tx_left"}, exp_tx.size(), 0);
        check({name, "_resp_left"}, exp_resp.size(), 0);
        exp_tx.delete();
        exp_resp.delete();
    endtask

    task automatic rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_tx();
        int n = 0;
        while (!tx_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_wait: got no tx_valid required one within 300 cycles");
        end
    endtask

    task automatic xfer();
        wait_tx();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic xfer_err();
        wait_tx();
        @(negedge clk);
        tx_err = 1'b1;
        @(negedge clk);
        tx_err = 1'b0;
    endtask

    task automatic pulse_init();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
    endtask

    task automatic host_send(input logic [7:0] b);
        int n = 0;
        host_cmd_data  = b;
        host_cmd_valid = 1'b1;
        while (!host_cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!host_cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL host_accept: got ready=0 required 1 within 300 cycles");
        end
        @(negedge clk);
        host_cmd_valid = 1'b0;
    endtask

    // Device side after FF went out: ACK, BAT ok, ID 00, then ACK the remaining four bytes.
    task automatic device_init_rest();
        rx(8'hFA);
        rx(8'hAA);
        rx(8'h00);
        repeat (4) begin
            xfer();
            rx(8'hFA);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test required finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        #2;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_host_ready", host_cmd_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_init_done", init_done, 0);
        check("rst_fail", fail, 0);
        check("rst_err_code", err_code, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_host_ready", host_cmd_ready, 1);

        // plain init
        expect_init(1);
        pulse_init();
        xfer();
        check("init_busy", busy, 1);
        check("init_host_ready", host_cmd_ready, 0);
        device_init_rest();
        check("init1_done", init_done, 1);
        check("init1_busy", busy, 0);
        drained("init1");

        // F3 resent twice before ACK
        expect_init(3);
        pulse_init();
        check("init2_done_cleared", init_done, 0);
        xfer();
        rx(8'hFA); rx(8'hAA); rx(8'h00);
        xfer(); rx(8'hFA);
        xfer(); rx(8'hFE);
        xfer(); rx(8'hFE);
        xfer(); rx(8'hFA);
        xfer(); rx(8'hFA);
        xfer(); rx(8'hFA);
        check("init2_done", init_done, 1);
        drained("init2");

        // F6 never acknowledged: one error reply then timeouts, four sends in total
        exp_tx.push_back(8'hFF);
        repeat (4) exp_tx.push_back(8'hF6);
        exp_resp.push_back(8'h00);
        pulse_init();
        xfer();
        rx(8'hFA); rx(8'hAA); rx(8'h00);
        xfer(); rx(8'hFC);
        repeat (3) xfer();
        repeat (40) @(negedge clk);
        check("ackfail_fail", fail, 1);
        check("ackfail_err", err_code, 1);
        check("ackfail_busy", busy, 0);
        check("ackfail_init_done", init_done, 0);
        drained("ackfail");

        // restart from FAIL; host F2 held off until init completes
        expect_init(1);
        exp_tx.push_back(8'hF2);
        exp_resp.push_back(8'h00);
        pulse_init();
        check("restart_fail_clear", fail, 0);
        check("restart_err_clear", err_code, 0);
        host_cmd_data  = 8'hF2;
        host_cmd_valid = 1'b1;
        xfer();
        check("hold_ready_ff", host_cmd_ready, 0);
        rx(8'hFA); rx(8'hAA); rx(8'h00);
        repeat (4) begin
            xfer();
            check("hold_ready_rom", host_cmd_ready, 0);
            rx(8'hFA);
        end
        check("hold_init_done", init_done, 1);
        check("hold_ready_after", host_cmd_ready, 1);
        @(negedge clk);
        host_cmd_valid = 1'b0;
        xfer();
        rx(8'hFA);
        rx(8'h00);
        @(negedge clk);
        drained("hostwait");

        // IDLE forwarding, then init_start during a host command
        exp_resp.push_back(8'h08);
        rx(8'h08);
        exp_tx.push_back(8'hF5);
        expect_init(1);
        host_send(8'hF5);
        xfer();
        pulse_init();
        repeat (5) begin
            check("deferred_no_tx", tx_valid, 0);
            @(negedge clk);
        end
        check("deferred_busy", busy, 1);
        rx(8'hFA);
        xfer();
        device_init_rest();
        check("deferred_done", init_done, 1);
        drained("deferred");

        // host FF walks the BAT/ID path and stops there
        exp_tx.push_back(8'hFF);
        exp_resp.push_back(8'h00);
        host_send(8'hFF);
        xfer();
        rx(8'hFA); rx(8'hAA); rx(8'h00);
        repeat (20) @(negedge clk);
        check("hostff_busy", busy, 0);
        check("hostff_init_done_kept", init_done, 1);
        drained("hostff");

        // BAT error reply
        exp_tx.push_back(8'hFF);
        host_send(8'hFF);
        xfer();
        rx(8'hFA);
        rx(8'hFC);
        @(negedge clk);
        check("bat_fail", fail, 1);
        check("bat_err", err_code, 2);
        check("bat_busy", busy, 0);
        drained("bat");

        // transmitter errors exhaust the retries
        repeat (4) exp_tx.push_back(8'hFF);
        pulse_init();
        check("txerr_fail_clear", fail, 0);
        repeat (4) xfer_err();
        repeat (3) @(negedge clk);
        check("txerr_fail", fail, 1);
        check("txerr_err", err_code, 3);
        check("txerr_busy", busy, 0);
        drained("txerr");

        // reset while waiting for the ACK abandons everything
        exp_tx.push_back(8'hFF);
        pulse_init();
        xfer();
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_host_ready", host_cmd_ready, 0);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_fail", fail, 0);
        check("midrst_err", err_code, 0);
        check("midrst_init_done", init_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_tx_valid", tx_valid, 0);
        drained("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_sched.md
PS2_CMD_SCHED -- requirements
Module: ps2_cmd_sched

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1000000, clk cycles allowed from tx_done to the ACK byte (20 ms at 50 MHz).
REQ-002 Parameter MAX_RETRY, default 3, resends allowed per command byte before failure.
REQ-003 Parameter BAT_TIMEOUT, default 50000000, clk cycles allowed from the reset ACK to the BAT byte.
REQ-004 clk  in  1  single clock; all logic in this domain.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 init_start  in  1  one-cycle pulse; requests the built-in mouse init sequence.
REQ-007 host_cmd_valid / host_cmd_data / host_cmd_ready  in / in 8 / out 1  external (UART-sourced) command byte; valid/ready handshake.
REQ-008 tx_valid / tx_data / tx_ready  out 1 / out 8 / in 1  byte request to the PS/2 host transmitter.
REQ-009 tx_done / tx_err  in 1 / in 1  one-cycle pulses: transmitter finished the byte / aborted on a line error.
REQ-010 rx_valid / rx_data  in 1 / in 8  byte received from the device.
REQ-011 resp_valid / resp_data  out 1 / out 8  non-protocol device bytes forwarded to the UART path.
REQ-012 busy / init_done / fail / err_code  out 1 / 1 / 1 / 2  status outputs.

Function
REQ-013 The init ROM SHALL hold FF, F6, F3, C8, F4 (reset, set default, set sample rate, 200 Hz, enable reporting), sent in that order.
REQ-014 States SHALL be IDLE, SEND, WAIT_DONE, WAIT_ACK, WAIT_BAT, WAIT_ID, FAIL.
REQ-015 IDLE: a pending init SHALL win over host_cmd_valid; host_cmd_ready SHALL be 1 only in IDLE with no init pending.
REQ-016 An init_start arriving while a host command is in flight SHALL be latched and start on the next return to IDLE.
REQ-017 An init_start arriving while init is running SHALL be ignored.
REQ-018 SEND: tx_valid=1 holding the current byte; the transfer completes when tx_valid&tx_ready, then go to WAIT_DONE.
REQ-019 WAIT_DONE: tx_done -> WAIT_ACK with the timeout counter cleared; tx_err counts as a retry.
REQ-020 WAIT_ACK, FA received: advance. After FF go to WAIT_BAT; after the last ROM byte or a host byte go to IDLE; otherwise go to SEND with the next byte.
REQ-021 WAIT_ACK, FE or FC received, or ACK_TIMEOUT expired: resend the same byte and increment the retry count.
REQ-022 The retry count SHALL reset to 0 on each new byte.
REQ-023 When the retry count would exceed MAX_RETRY, go to FAIL.
REQ-024 WAIT_ACK, any other byte: forward it on resp and keep waiting.
REQ-025 WAIT_BAT: AA -> WAIT_ID; FC or BAT_TIMEOUT -> FAIL. WAIT_ID: the next byte (expected 00) is forwarded on resp, then send F6.
REQ-026 In IDLE, every rx byte SHALL be forwarded: resp_valid one cycle, same cycle-plus-one as rx_valid; no buffering.
REQ-027 A host command of FF SHALL follow the same BAT/ID path but SHALL NOT continue into the ROM.
REQ-028 err_code values: 0 none, 1 ACK retries exhausted, 2 BAT failed or timed out, 3 transmit error retries exhausted.
REQ-029 fail and err_code SHALL hold until the next init_start, which clears them and restarts init from FF.
REQ-030 busy=1 in every state except IDLE and FAIL.
REQ-031 init_done SHALL set when the F4 ACK is received and clear on init_start.
REQ-032 Timeout counters SHALL be wide enough for max(ACK_TIMEOUT, BAT_TIMEOUT) and SHALL saturate, not wrap.
REQ-033 rx_valid coincident with a timeout expiry: the received byte SHALL take priority.

Reset
REQ-034 On rst low: state IDLE, no init pending, counters 0, and all outputs 0 (tx_valid, tx_data, host_cmd_ready, resp_valid, resp_data, busy, init_done, fail, err_code).
REQ-035 Reset mid-transfer SHALL abandon the byte; no auto-restart, since init requires a new init_start.

Structure
REQ-036 The PS/2 command/response byte constants (FF, F6, F3, F4, FA, FE, FC, AA), the state enum and the err_code enum SHALL live in the shared ps2 package.
REQ-037 The init ROM SHALL be a sub-module, ps2_init_rom: index in, byte and last-flag out, purely combinational.

Verification
REQ-038 init_start, device ACKs every byte and sends AA, 00 -> tx bytes FF,F6,F3,C8,F4 in order; resp shows 00; init_done=1, busy=0.
REQ-039 Device answers FE twice to F3, then FA -> F3 transmitted 3 times; sequence completes with init_done=1.
REQ-040 Device never ACKs F6 (MAX_RETRY=3) -> F6 sent 4 times; fail=1, err_code=1, busy=0.
REQ-041 host_cmd F2 while init is running -> host_cmd_ready=0 until init_done; then F2 is sent; ACK FA, then 00 forwarded on resp.
REQ-042 init_start during a host command -> init starts only after that command's ACK.
REQ-043 rst pulse while in WAIT_ACK -> all outputs return to 0 asynchronously; no tx_valid until a new init_start.
